// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - load-use stall and registered EX operand forwarding selects
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [1:0] SEL_RF     = 2'b00;
    localparam logic [1:0] SEL_EX_MEM = 2'b10;
    localparam logic [1:0] SEL_MEM_WB = 2'b01;

    // EX and MEM tracking entries. The WB entry is not kept: a producer is
    // only ever forwarded from while it sits in EX or MEM at the ID->EX
    // transfer, and once it reaches WB the register file supplies its value.
    logic                  ex_valid;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_valid;
    logic                  mem_regwrite;
    logic [REG_ADDR_W-1:0] mem_rd;

    logic                  ex_is_load;
    logic                  load_use;
    logic [1:0]            next_fwd_a;
    logic [1:0]            next_fwd_b;

    // A stage writes r when it holds a live register-writing instruction
    // targeting r; x0 is never treated as a producer.
    function automatic logic stage_writes(
        input logic                  v,
        input logic                  rw,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] r
    );
        return v & rw & (rd == r) & (r != '0);
    endfunction

    // Nearest producer wins: the EX entry will be in MEM (EX/MEM result)
    // when the consumer reaches EX, the MEM entry will be in WB.
    function automatic logic [1:0] pick_sel(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] r
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (used) begin
            if (stage_writes(ex_valid, ex_regwrite, ex_rd, r)) begin
                sel = SEL_EX_MEM;
            end else if (stage_writes(mem_valid, mem_regwrite, mem_rd, r)) begin
                sel = SEL_MEM_WB;
            end
        end
        return sel;
    endfunction

    // Load-use detection against the load currently in EX; flush masks it.
    always_comb begin
        ex_is_load = ex_valid & ex_memread & ex_regwrite & (ex_rd != '0);
        load_use   = ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));
        stall      = id_valid & ~flush & ex_is_load & load_use;
    end

    // Next forwarding selects; a bubble entering EX needs no forwarding.
    always_comb begin
        next_fwd_a = SEL_RF;
        next_fwd_b = SEL_RF;
        if (id_valid && !flush && !stall) begin
            next_fwd_a = pick_sel(id_use_rs1, id_rs1);
            next_fwd_b = pick_sel(id_use_rs2, id_rs2);
        end
    end

    // Advance the tracking pipeline; flush or stall inserts a bubble into EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rd        <= '0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_rd       <= '0;
        end else begin
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_rd       <= ex_rd;
            if (flush || stall) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid <= id_valid;
            end
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_rd       <= id_rd;
        end
    end

    // Registered forwarding selects, valid while the consumer occupies EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            forward_a <= SEL_RF;
            forward_b <= SEL_RF;
        end else begin
            forward_a <= next_fwd_a;
            forward_b <= next_fwd_b;
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - table-driven bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

    localparam int RW = 5;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [RW-1:0] id_rd;
    logic          id_regwrite;
    logic          id_memread;
    logic          flush;
    logic [1:0]    forward_a;
    logic [1:0]    forward_b;
    logic          stall;
    logic [CW-1:0] stall_count;

    int total;
    int bad;

    hazard_forward_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .stall       (stall),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [RW-1:0] rd;
        logic          rw;
        logic          mr;
        logic          fl;
        logic          e_stall;
        logic [1:0]    e_fa;
        logic [1:0]    e_fb;
        logic [CW-1:0] e_cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
        input int rd, input logic rw, input logic mr, input logic fl,
        input logic es, input logic [1:0] efa, input logic [1:0] efb, input int ecnt
    );
        vec_t t;
        t.v = v; t.rs1 = RW'(rs1); t.rs2 = RW'(rs2); t.u1 = u1; t.u2 = u2;
        t.rd = RW'(rd); t.rw = rw; t.mr = mr; t.fl = fl;
        t.e_stall = es; t.e_fa = efa; t.e_fb = efb; t.e_cnt = CW'(ecnt);
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid    = t.v;
        id_rs1      = t.rs1;
        id_rs2      = t.rs2;
        id_use_rs1  = t.u1;
        id_use_rs2  = t.u2;
        id_rd       = t.rd;
        id_regwrite = t.rw;
        id_memread  = t.mr;
        flush       = t.fl;
    endtask

    // One cycle: stall checked before the edge, selects and count after it.
    task automatic step(input string tag, input vec_t t);
        @(negedge clk);
        drive(t);
        #1;
        chk({tag, " stall"}, int'(stall), int'(t.e_stall));
        @(posedge clk);
        #1;
        chk({tag, " forward_a"}, int'(forward_a), int'(t.e_fa));
        chk({tag, " forward_b"}, int'(forward_b), int'(t.e_fb));
        chk({tag, " stall_count"}, int'(stall_count), int'(t.e_cnt));
    endtask

    initial begin
        int exp_cnt;
        vec_t t;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));

        //            v rs1 rs2 u1 u2 rd rw mr fl  stall fa     fb     cnt
        vecs[0]  = mk(1, 1,  2,  1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0); // add x5
        vecs[1]  = mk(1, 5,  1,  1, 1, 6, 1, 0, 0, 0, 2'b10, 2'b00, 0); // sub uses x5
        vecs[2]  = mk(1, 9,  10, 1, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        vecs[3]  = mk(1, 5,  6,  1, 1, 11, 1, 0, 0, 0, 2'b00, 2'b01, 0); // x5 in WB, x6 in MEM
        vecs[4]  = mk(1, 2,  0,  1, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 0); // lw x7
        vecs[5]  = mk(1, 1,  7,  1, 1, 12, 1, 0, 0, 1, 2'b00, 2'b00, 1); // load-use stall
        vecs[6]  = mk(1, 1,  7,  1, 1, 12, 1, 0, 0, 0, 2'b00, 2'b01, 1); // re-evaluate
        vecs[7]  = mk(1, 1,  0,  1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1); // writes x0
        vecs[8]  = mk(1, 0,  0,  1, 1, 13, 1, 0, 0, 0, 2'b00, 2'b00, 1); // reads x0
        vecs[9]  = mk(1, 1,  2,  1, 1, 3, 1, 1, 0, 0, 2'b00, 2'b00, 1); // lw x3
        vecs[10] = mk(1, 3,  4,  0, 1, 14, 1, 0, 0, 0, 2'b00, 2'b00, 1); // rs1=x3 unused
        vecs[11] = mk(1, 1,  2,  1, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00, 1); // add x4
        vecs[12] = mk(1, 4,  0,  1, 0, 4, 1, 0, 0, 0, 2'b10, 2'b00, 1); // addi x4
        vecs[13] = mk(1, 4,  4,  1, 1, 15, 1, 0, 0, 0, 2'b10, 2'b10, 1); // newest writer wins
        vecs[14] = mk(1, 1,  0,  1, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00, 1); // lw x9
        vecs[15] = mk(1, 9,  0,  1, 0, 16, 1, 0, 1, 0, 2'b00, 2'b00, 1); // hazard + flush
        vecs[16] = mk(1, 9,  0,  1, 0, 16, 1, 0, 0, 0, 2'b01, 2'b00, 1);
        vecs[17] = mk(1, 9,  0,  1, 0, 20, 1, 1, 0, 0, 2'b00, 2'b00, 1); // lw x20
        vecs[18] = mk(1, 1,  20, 1, 1, 17, 1, 0, 0, 1, 2'b00, 2'b00, 2);
        vecs[19] = mk(1, 1,  20, 1, 1, 17, 1, 0, 0, 0, 2'b00, 2'b01, 2);

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            id_valid    = 1'($urandom);
            id_rs1      = RW'($urandom);
            id_rs2      = RW'($urandom);
            id_use_rs1  = 1'($urandom);
            id_use_rs2  = 1'($urandom);
            id_rd       = RW'($urandom);
            id_regwrite = 1'($urandom);
            id_memread  = 1'($urandom);
            flush       = 1'($urandom);
            #1;
            chk("reset stall", int'(stall), 0);
            chk("reset forward_a", int'(forward_a), 0);
            chk("reset forward_b", int'(forward_b), 0);
            chk("reset stall_count", int'(stall_count), 0);
        end
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Repeated load-use pairs drive the 3-bit counter into saturation.
        exp_cnt = 2;
        for (int i = 0; i < 7; i++) begin
            step($sformatf("sat%0d lw", i), mk(1, 1, 0, 1, 0, 21, 1, 1, 0, 0, 2'b00, 2'b00, exp_cnt));
            exp_cnt = (exp_cnt < 7) ? exp_cnt + 1 : 7;
            step($sformatf("sat%0d use", i), mk(1, 21, 2, 1, 1, 18, 1, 0, 0, 1, 2'b00, 2'b00, exp_cnt));
            step($sformatf("sat%0d retry", i), mk(1, 21, 2, 1, 1, 18, 1, 0, 0, 0, 2'b01, 2'b00, exp_cnt));
        end

        // Reset asserted mid-stream while a load-use pair is pending.
        step("mid lw", mk(1, 1, 0, 1, 0, 22, 1, 1, 0, 0, 2'b00, 2'b00, 7));
        @(negedge clk);
        t = mk(1, 22, 0, 1, 0, 19, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        drive(t);
        #1;
        chk("mid pre-reset stall", int'(stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid async stall", int'(stall), 0);
        chk("mid async stall_count", int'(stall_count), 0);
        chk("mid async forward_a", int'(forward_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post reset", t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard controller for the 5-stage RISC-V core: tracks destination registers of in-flight instructions in EX, MEM and WB, and generates the registered 2-bit forwarding selects consumed by the EX-stage operand forwarding muxes. It also detects load-use hazards and drives a one-cycle stall. Branch flushes clear the EX entry.

## Interface
- `REG_ADDR_W`, default 5: register index width.
- `CNT_W`, default 32: width of the stall statistics counter.

- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_valid`  in  1  a real instruction is in ID.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W each  ID source register indices.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the instruction reads that source.
- `id_rd`  in  REG_ADDR_W  ID destination register index.
- `id_regwrite`  in  1  the ID instruction writes `id_rd`.
- `id_memread`  in  1  the ID instruction is a load.
- `flush`  in  1  taken branch/jump resolved in EX; kill ID and EX contents.
- `forward_a`  out  2  operand-1 select for the EX instruction: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- `forward_b`  out  2  same encoding, operand 2.
- `stall`  out  1  hold PC and IF/ID this cycle; combinational.
- `stall_count`  out  CNT_W  saturating count of stall cycles.

## Operation
- Internal tracking stages EX, MEM, WB. Each stage holds `valid`, `rd` and `regwrite`. EX also holds `memread`.
- A stage "writes r" when `valid & regwrite & rd==r & r!=0`. Register x0 is never a hazard or forward source.
- Every cycle, WB <= MEM and MEM <= EX.
- EX is loaded as follows:
  - `flush`=1: EX becomes a bubble (valid=0).
  - Else `stall`=1: EX becomes a bubble.
  - Else EX captures the ID fields, with valid=`id_valid`.
- Load-use hazard:
  - `stall` = `id_valid & !flush & EX.valid & EX.memread & EX.regwrite & EX.rd!=0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd))`.
  - Because EX receives a bubble, a stall lasts exactly one cycle per load-use pair.
- Forward select generation is registered and computed at the ID->EX transfer, for each used source s (rs1 -> `forward_a`, rs2 -> `forward_b`):
  - If the current EX entry writes s, next select is 10. That instruction will be in MEM when the consumer is in EX.
  - Else if the current MEM entry writes s, next select is 01.
  - Else 00. EX/MEM takes priority over MEM/WB.
  - An unused source gives 00.
  - On flush or stall, both selects load 00, since the bubble needs no forwarding.
  - 11 is never produced.
- After a stall, the consumer re-evaluates next cycle. The load is then in MEM and the consumer selects 01 (MEM/WB result, which is the load data).
- `stall_count` increments on each cycle with `stall`=1 and saturates at all-ones.

## Timing
- Reset (async, `rst_n`=0):
  - All stage valids = 0.
  - `forward_a` = `forward_b` = 2'b00.
  - `stall_count` = 0.
  - `stall` = 0, since it derives from EX.valid.
- Forward selects: 1-cycle latency. They are valid during the cycle the instruction occupies EX, i.e. the cycle after the ID inputs are sampled.
- `stall`: zero-cycle combinational from ID inputs and registered EX state. `flush` masks it in the same cycle.
- Simultaneous `flush` and hazard: flush wins. `stall`=0, EX gets a bubble, and the count is unchanged.
- Reset released mid-stream: the first instruction after reset sees an empty pipeline and gets selects 00.
- Back-to-back writers of the same rd: the nearest (EX) writer always wins.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> selects 00, `stall`=0, `stall_count`=0.
- ALU chain: `add x5` then `sub` using rs1=x5 in the next cycle -> `forward_a`=10 in the sub's EX cycle. A third instruction reading x5 two cycles later -> 01.
- Load-use: `lw x7` followed by `add` with rs2=x7:
  - `stall`=1 for one cycle and `stall_count`=1.
  - Next cycle `stall`=0, and in the add's EX cycle `forward_b`=01.
- x0 and unused sources:
  - Writer rd=x0, consumer rs1=x0 -> select 00, no stall.
  - Load to x3, consumer with `id_use_rs1`=0 and rs1=x3 -> no stall.
- Double writer: `add x4` then `addi x4`, then a consumer of x4 -> `forward_a`=10 (the newest writer).
- Flush priority: load-use condition plus `flush`=1 in the same cycle -> `stall`=0, EX bubble, selects 00 next cycle, `stall_count` unchanged.
